// File: rtl/timing_decode_team1.sv
// Timing/decode stage of the basic computer: one-hot T from SC, IR/I registers,
// opcode decode D, class flags r/p, and the R/IEN/HLT control flip-flops.
module timing_decode_team1 (
    input  logic        clk,
    input  logic        CLR_GLOBAL,
    input  logic [3:0]  SC,
    input  logic [15:0] BUS,
    input  logic        FGI,
    input  logic        FGO,
    output logic [15:0] T,
    output logic [15:0] IR,
    output logic        I,
    output logic [7:0]  D,
    output logic [11:0] B,
    output logic        r,
    output logic        p,
    output logic        R,
    output logic        IEN,
    output logic        HLT
);

    logic [15:0] r_ir;
    logic        r_i;
    logic        r_r;
    logic        r_ien;
    logic        r_hlt;

    logic [15:0] w_t;
    logic [7:0]  w_d;
    logic        w_reg_class;
    logic        w_io_class;
    logic        w_ir_load;
    logic        w_i_load;
    logic        w_r_set;
    logic        w_r_clear;
    logic        w_iof;
    logic        w_ion;
    logic        w_hlt_set;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_t_decode
            assign w_t[gi] = (SC == 4'(gi));
        end
        for (gi = 0; gi < 8; gi++) begin : g_d_decode
            assign w_d[gi] = (r_ir[14:12] == 3'(gi));
        end
    endgenerate

    assign w_reg_class = w_d[7] & ~r_i;
    assign w_io_class  = w_d[7] &  r_i;

    // Fetch loads are suppressed during the interrupt cycle and while halted.
    assign w_ir_load = w_t[1] & ~r_r & ~r_hlt;
    assign w_i_load  = w_t[2] & ~r_r & ~r_hlt;
    assign w_r_clear = r_r & w_t[2];
    assign w_r_set   = ~(w_t[0] | w_t[1] | w_t[2]) & r_ien & (FGI | FGO) & ~r_hlt;
    assign w_iof     = w_io_class & r_ir[6] & w_t[3];
    assign w_ion     = w_io_class & r_ir[7] & w_t[3];
    assign w_hlt_set = w_reg_class & r_ir[0] & w_t[3];

    always_ff @(posedge clk) begin
        if (CLR_GLOBAL) begin
            r_ir  <= 16'h0000;
            r_i   <= 1'b0;
            r_r   <= 1'b0;
            r_ien <= 1'b0;
            r_hlt <= 1'b0;
        end else begin
            if (w_ir_load) begin
                r_ir <= BUS;
            end else begin
                r_ir <= r_ir;
            end

            if (w_i_load) begin
                r_i <= r_ir[15];
            end else begin
                r_i <= r_i;
            end

            // R is frozen while halted; clear has priority over set.
            if (r_hlt) begin
                r_r <= r_r;
            end else if (w_r_clear) begin
                r_r <= 1'b0;
            end else if (w_r_set) begin
                r_r <= 1'b1;
            end else begin
                r_r <= r_r;
            end

            if (w_r_clear) begin
                r_ien <= 1'b0;
            end else if (w_iof) begin
                r_ien <= 1'b0;
            end else if (w_ion) begin
                r_ien <= 1'b1;
            end else begin
                r_ien <= r_ien;
            end

            if (w_hlt_set) begin
                r_hlt <= 1'b1;
            end else begin
                r_hlt <= r_hlt;
            end
        end
    end

    assign T   = w_t;
    assign IR  = r_ir;
    assign I   = r_i;
    assign D   = w_d;
    assign B   = r_ir[11:0];
    assign r   = w_reg_class;
    assign p   = w_io_class;
    assign R   = r_r;
    assign IEN = r_ien;
    assign HLT = r_hlt;

endmodule
